// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

   // FSM state encoding
   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'b00;
   localparam state_t S_BUSY = 2'b01;
   localparam state_t S_DONE = 2'b10;

   // Operation encoding: op[0] selects subtract, op[1] selects external carry-in
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;

   // Result status flags, kept together so they load as one register
   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } flags_t;

   // Initial carry: external cin for chained ops, otherwise 1 for subtract (two's complement)
   function automatic logic carry_in(input logic [1:0] op, input logic cin);
      return op[1] ? cin : op[0];
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-wide ripple slice: sum, carry out of the slice and carry into its MSB.
module addsub_digit #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             cmsb
);

   logic [DIGIT:0] full_c;

   // Plain add with one guard bit for the carry out
   always_comb begin
      full_c = {1'b0, a} + {1'b0, b} + (DIGIT+1)'(ci);
   end

   // Carry into the MSB recovered from the MSB sum bit, valid for any DIGIT >= 1
   always_comb begin
      s    = full_c[DIGIT-1:0];
      co   = full_c[DIGIT];
      cmsb = full_c[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
   end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice first,
// with valid/ready handshakes on both the operand and the result side.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   // Reject geometries that do not split into whole slices
   if (DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("addsub_serial: WIDTH must be a non-zero multiple of DIGIT");
   end

   localparam int unsigned NSLICE = WIDTH / DIGIT;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_t             state;
   state_t             state_nxt;

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   acc_q;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   sum_q;
   flags_t             flags_q;

   logic [DIGIT-1:0]   d_sum;
   logic               d_cout;
   logic               d_cmsb;

   logic               accept_c;
   logic               release_c;
   logic               last_c;
   logic [WIDTH-1:0]   acc_nxt_c;

   // Single slice adder, reused on every BUSY cycle
   addsub_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a    (a_q[DIGIT-1:0]),
      .b    (b_q[DIGIT-1:0]),
      .ci   (carry_q),
      .s    (d_sum),
      .co   (d_cout),
      .cmsb (d_cmsb)
   );

   // Handshake qualifiers and slice bookkeeping
   always_comb begin
      accept_c  = in_valid && in_ready;
      release_c = out_valid && out_ready;
      last_c    = (state == S_BUSY) && (cnt_q == CNT_W'(NSLICE - 1));
      // New slice enters at the top; after NSLICE shifts the LSB slice sits at bit 0
      acc_nxt_c = (acc_q >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept_c) begin
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (last_c) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (release_c) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and registered handshake outputs.
   // out_valid follows one edge after DONE entry so the result registers
   // have settled for a full cycle before the consumer sees valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == S_IDLE);
         out_valid <= (state == S_DONE) && (state_nxt == S_DONE);
      end
   end

   // Operand capture and per-slice datapath; operand inputs are only sampled on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (state == S_IDLE && accept_c) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{op[0]}};
            carry_q <= carry_in(op, cin);
            cnt_q   <= '0;
         end else if (state == S_BUSY) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            acc_q   <= acc_nxt_c;
            carry_q <= d_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Result and flags load only on the final slice, then hold until the next result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         flags_q <= '0;
      end else if (last_c) begin
         sum_q        <= acc_nxt_c;
         flags_q.cout <= d_cout;
         flags_q.ovf  <= d_cmsb ^ d_cout;
         flags_q.zero <= (acc_nxt_c == '0);
         flags_q.neg  <= acc_nxt_c[WIDTH-1];
      end
   end

   // Drive ports straight from the result registers
   always_comb begin
      sum  = sum_q;
      cout = flags_q.cout;
      ovf  = flags_q.ovf;
      zero = flags_q.zero;
      neg  = flags_q.neg;
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and randomized bench for addsub_serial (16/4, 8/8 and 32/2 geometries).
module tb_addsub_serial;
   import addsub_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Main instance, WIDTH=16 DIGIT=4
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf, zero, neg;
   logic [15:0] a, b, sum;
   logic [1:0]  op;

   addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg));

   // Regression instance, WIDTH=8 DIGIT=8
   logic       r8_iv, r8_ir, r8_ov, r8_or, r8_cin, r8_cout, r8_ovf, r8_zero, r8_neg;
   logic [7:0] r8_a, r8_b, r8_sum;
   logic [1:0] r8_op;

   addsub_serial #(.WIDTH(8), .DIGIT(8)) u_r8 (
      .clk(clk), .rst_n(rst_n), .in_valid(r8_iv), .in_ready(r8_ir),
      .a(r8_a), .b(r8_b), .op(r8_op), .cin(r8_cin), .out_valid(r8_ov), .out_ready(r8_or),
      .sum(r8_sum), .cout(r8_cout), .ovf(r8_ovf), .zero(r8_zero), .neg(r8_neg));

   // Regression instance, WIDTH=32 DIGIT=2
   logic        r32_iv, r32_ir, r32_ov, r32_or, r32_cin, r32_cout, r32_ovf, r32_zero, r32_neg;
   logic [31:0] r32_a, r32_b, r32_sum;
   logic [1:0]  r32_op;

   addsub_serial #(.WIDTH(32), .DIGIT(2)) u_r32 (
      .clk(clk), .rst_n(rst_n), .in_valid(r32_iv), .in_ready(r32_ir),
      .a(r32_a), .b(r32_b), .op(r32_op), .cin(r32_cin), .out_valid(r32_ov), .out_ready(r32_or),
      .sum(r32_sum), .cout(r32_cout), .ovf(r32_ovf), .zero(r32_zero), .neg(r32_neg));

   // Single comparison point
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference: a + (b ^ mask(op[0])) + c0 over w bits; returns {cout,ovf,zero,neg,sum}
   function automatic logic [35:0] model(input logic [31:0] va, input logic [31:0] vb,
                                          input logic [1:0] vop, input logic vcin, input int w);
      logic [31:0] m, am, bx, s;
      logic [32:0] full;
      logic        c0, co, ov;
      m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      am   = va & m;
      bx   = (vop[0] ? ~vb : vb) & m;
      c0   = vop[1] ? vcin : vop[0];
      full = {1'b0, am} + {1'b0, bx} + 33'(c0);
      s    = full[31:0] & m;
      co   = full[w];
      ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
      return {co, ov, (s == 32'd0), s[w-1], s};
   endfunction

   // Present one operand set and wait for its acceptance edge; then scribble on the inputs
   task automatic start_op(input logic [15:0] va, input logic [15:0] vb,
                           input logic [1:0] vop, input logic vcin);
      int i = 0;
      while (!in_ready && i < 50) begin
         @(posedge clk); #1; i++;
      end
      a = va; b = vb; op = vop; cin = vcin; in_valid = 1'b1;
      @(posedge clk); #1;
      a = ~va; b = 16'hA5A5; op = ~vop; cin = ~vcin;
   endtask

   // Count edges from the acceptance edge until out_valid, bounded
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   // Complete the result handshake and confirm the return to IDLE
   task automatic release_out(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
      check({tag, "_idle_ov"}, 64'(out_valid), 64'd0);
   endtask

   // One directed vector: latency, sum and {cout,ovf,zero,neg}
   task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [1:0] vop, input logic vcin,
                          input logic [15:0] es, input logic [3:0] ef);
      int lat;
      start_op(va, vb, vop, vcin);
      wait_valid(lat);
      check({tag, "_lat"}, 64'(lat), 64'd5);
      check({tag, "_sum"}, 64'(sum), 64'(es));
      check({tag, "_flags"}, 64'({cout, ovf, zero, neg}), 64'(ef));
      release_out(tag);
   endtask

   // Random traffic on the 8/8 instance
   task automatic regress8(input int cycles);
      logic [35:0] q[$];
      logic [35:0] e;
      int          done = 0;
      for (int i = 0; i < cycles; i++) begin
         r8_iv  = 1'($urandom_range(0, 1));
         r8_a   = 8'($urandom);
         r8_b   = 8'($urandom);
         r8_op  = 2'($urandom);
         r8_cin = 1'($urandom);
         r8_or  = ($urandom_range(0, 3) != 0);
         if (r8_iv && r8_ir) q.push_back(model(32'(r8_a), 32'(r8_b), r8_op, r8_cin, 8));
         if (r8_ov && r8_or) begin
            if (q.size() == 0) begin
               check("r8_orphan", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("r8_sum", 64'(r8_sum), 64'(e[7:0]));
               check("r8_flags", 64'({r8_cout, r8_ovf, r8_zero, r8_neg}), 64'(e[35:32]));
               done++;
            end
         end
         @(posedge clk); #1;
      end
      r8_iv = 1'b0;
      check("r8_enough", 64'(done >= 20), 64'd1);
   endtask

   // Random traffic on the 32/2 instance
   task automatic regress32(input int cycles);
      logic [35:0] q[$];
      logic [35:0] e;
      int          done = 0;
      for (int i = 0; i < cycles; i++) begin
         r32_iv  = 1'($urandom_range(0, 1));
         r32_a   = $urandom;
         r32_b   = $urandom;
         r32_op  = 2'($urandom);
         r32_cin = 1'($urandom);
         r32_or  = ($urandom_range(0, 3) != 0);
         if (r32_iv && r32_ir) q.push_back(model(r32_a, r32_b, r32_op, r32_cin, 32));
         if (r32_ov && r32_or) begin
            if (q.size() == 0) begin
               check("r32_orphan", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("r32_sum", 64'(r32_sum), 64'(e[31:0]));
               check("r32_flags", 64'({r32_cout, r32_ovf, r32_zero, r32_neg}), 64'(e[35:32]));
               done++;
            end
         end
         @(posedge clk); #1;
      end
      r32_iv = 1'b0;
      check("r32_enough", 64'(done >= 20), 64'd1);
   endtask

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = OP_ADD; cin = 1'b0;
      r8_iv = 1'b0; r8_or = 1'b0; r8_a = '0; r8_b = '0; r8_op = '0; r8_cin = 1'b0;
      r32_iv = 1'b0; r32_or = 1'b0; r32_a = '0; r32_b = '0; r32_op = '0; r32_cin = 1'b0;

      // Reset state
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum_flags", 64'({sum, cout, ovf, zero, neg}), 64'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors; ADD ignores cin (set to 1 here on purpose)
      run_vec("add_ovf",  16'h7FFF, 16'h0001, OP_ADD, 1'b1, 16'h8000, 4'b0101);
      run_vec("sub_zero", 16'h0005, 16'h0005, OP_SUB, 1'b0, 16'h0000, 4'b1010);
      run_vec("sub_neg",  16'h0003, 16'h0005, OP_SUB, 1'b0, 16'hFFFE, 4'b0001);
      run_vec("adc_wrap", 16'hFFFF, 16'h0000, OP_ADC, 1'b1, 16'h0000, 4'b1010);
      run_vec("sbb_brw",  16'h0000, 16'h0000, OP_SBB, 1'b0, 16'hFFFF, 4'b0001);
      run_vec("add_mm",   16'h8000, 16'h8000, OP_ADD, 1'b0, 16'h0000, 4'b1110);
      run_vec("sub_ovf",  16'h8000, 16'h0001, OP_SUB, 1'b1, 16'h7FFF, 4'b1100);
      run_vec("adc_c0",   16'h00FF, 16'h0001, OP_ADC, 1'b0, 16'h0100, 4'b0000);

      // Backpressure: result held while out_ready is low, new operands ignored
      begin
         int lat;
         start_op(16'h1111, 16'h2222, OP_ADD, 1'b0);
         wait_valid(lat);
         check("bp_lat", 64'(lat), 64'd5);
         for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a = 16'(16'h0100 * k); b = 16'h7777; op = OP_SUB;
            @(posedge clk); #1;
            check("bp_sum", 64'(sum), 64'h3333);
            check("bp_flags", 64'({cout, ovf, zero, neg}), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
         end
         release_out("bp");
         seen = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
         end
         check("bp_no_accept", 64'(seen), 64'd0);
      end

      // Reset in the 2nd BUSY cycle aborts the operation (previous sum 0x3333 is nonzero)
      start_op(16'h0F0F, 16'h0101, OP_ADD, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_sum_flags", 64'({sum, cout, ovf, zero, neg}), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", 64'(seen), 64'd0);
      run_vec("post_rst", 16'h1234, 16'h4321, OP_ADD, 1'b0, 16'h5555, 4'b0000);

      // Randomized regression on the other geometries
      fork
         regress8(1500);
         regress32(1500);
      join

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
